// File: rtl/ci_seq_pkg.sv
// Shared definitions for the custom-instruction sequencer: opcodes, the
// sentinel result words and the control FSM state type.
package ci_seq_pkg;

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_POP   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [31:0] ERR_FULL  = 32'hFFFF_FFFF;
    localparam logic [31:0] EMPTY_NAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_RUN
    } ci_state_t;

endpackage

// File: rtl/sync_fifo.sv
// 32-bit synchronous FIFO with wrap-bit pointers, a synchronous flush and an
// occupancy count. The read port always shows the current head word.
module sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [31:0]              wr_data_i,
    input  logic                     rd_en_i,
    output logic [31:0]              rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_wr, do_rd;

    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_wr = wr_en_i && !full_o && !flush_i;
    assign do_rd = rd_en_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty pointers make its contents unobservable.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/cordic_ci_sequencer.sv
// Nios II multicycle custom-instruction responder: batches operands, streams
// them through a fixed-latency pipeline and hands the results back one by one.
module cordic_ci_sequencer
    import ci_seq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result,
    output logic        pipe_en,
    output logic [31:0] pipe_dataa,
    input  logic [31:0] pipe_result
);
    localparam int CW = $clog2(DEPTH) + 1;

    ci_state_t          state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [31:0]        opnd_q, opnd_d;
    logic               done_q, done_d;
    logic [31:0]        result_q, result_d;
    logic [31:0]        pdata_q, pdata_d;
    logic               inj_q, inj_d;
    logic               issued_q, issued_d;
    logic [LATENCY-1:0] tag_q, tag_d;
    logic [CW-1:0]      k_q, k_d;

    logic          opf_flush, opf_wr, opf_rd, opf_full, opf_empty;
    logic [31:0]   opf_rdata;
    logic [CW-1:0] opf_count;
    logic          rsf_flush, rsf_wr, rsf_rd, rsf_full, rsf_empty;
    logic [31:0]   rsf_rdata;
    logic [CW-1:0] rsf_count;

    sync_fifo #(.DEPTH(DEPTH)) u_opnd_fifo (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .flush_i   (clk_en && opf_flush),
        .wr_en_i   (clk_en && opf_wr),
        .wr_data_i (opnd_q),
        .rd_en_i   (clk_en && opf_rd),
        .rd_data_o (opf_rdata),
        .full_o    (opf_full),
        .empty_o   (opf_empty),
        .count_o   (opf_count)
    );

    sync_fifo #(.DEPTH(DEPTH)) u_result_fifo (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .flush_i   (clk_en && rsf_flush),
        .wr_en_i   (clk_en && rsf_wr),
        .wr_data_i (pipe_result),
        .rd_en_i   (clk_en && rsf_rd),
        .rd_data_o (rsf_rdata),
        .full_o    (rsf_full),
        .empty_o   (rsf_empty),
        .count_o   (rsf_count)
    );

    assign pipe_en    = clk_en && (state_q == ST_RUN);
    assign pipe_dataa = pdata_q;
    assign done       = done_q;
    assign result     = result_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        done_d    = 1'b0;
        result_d  = result_q;
        pdata_d   = pdata_q;
        inj_d     = inj_q;
        issued_d  = issued_q;
        tag_d     = tag_q;
        k_d       = k_q;
        opf_flush = 1'b0;
        opf_wr    = 1'b0;
        opf_rd    = 1'b0;
        rsf_flush = 1'b0;
        rsf_wr    = 1'b0;
        rsf_rd    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d   = n;
                    opnd_d = dataa;
                    // First operand is loaded while entering RUN so the pipe sees it at E1.
                    if (n == OP_RUN && !opf_empty) begin
                        state_d   = ST_RUN;
                        k_d       = opf_count;
                        rsf_flush = 1'b1;
                        pdata_d   = opf_rdata;
                        opf_rd    = 1'b1;
                        inj_d     = 1'b1;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                unique case (op_q)
                    OP_PUSH: begin
                        if (!opf_full) begin
                            opf_wr   = 1'b1;
                            result_d = 32'(opf_count) + 32'd1;
                        end else begin
                            result_d = ERR_FULL;
                        end
                    end
                    OP_POP: begin
                        if (!rsf_empty) begin
                            rsf_rd   = 1'b1;
                            result_d = rsf_rdata;
                        end else begin
                            result_d = EMPTY_NAN;
                        end
                    end
                    OP_CLEAR: begin
                        opf_flush = 1'b1;
                        rsf_flush = 1'b1;
                        tag_d     = '0;
                        result_d  = '0;
                    end
                    default: result_d = '0;
                endcase
            end

            ST_RUN: begin
                // issued_q marks the operand the pipe took at the previous edge.
                tag_d    = tag_q << 1;
                tag_d[0] = issued_q;
                issued_d = inj_q;
                if (!opf_empty) begin
                    pdata_d = opf_rdata;
                    opf_rd  = 1'b1;
                    inj_d   = 1'b1;
                end else begin
                    inj_d = 1'b0;
                end
                if (tag_q[LATENCY-1] && !rsf_full) begin
                    rsf_wr = 1'b1;
                    if (CW'(rsf_count + CW'(1)) == k_q) begin
                        done_d   = 1'b1;
                        result_d = 32'(k_q);
                        state_d  = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_PUSH;
            opnd_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            pdata_q  <= '0;
            inj_q    <= 1'b0;
            issued_q <= 1'b0;
            tag_q    <= '0;
            k_q      <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            done_q   <= done_d;
            result_q <= result_d;
            pdata_q  <= pdata_d;
            inj_q    <= inj_d;
            issued_q <= issued_d;
            tag_q    <= tag_d;
            k_q      <= k_d;
        end
    end

endmodule

// File: tb/tb_cordic_ci_sequencer.sv
// Directed self-checking bench for cordic_ci_sequencer with a delay-line
// pipeline stub that returns each operand plus one, LATENCY edges later.
module tb_cordic_ci_sequencer;

    localparam int DEPTH = 8;
    localparam int LAT   = 16;

    localparam logic [1:0]  PUSH  = 2'd0;
    localparam logic [1:0]  RUN   = 2'd1;
    localparam logic [1:0]  POP   = 2'd2;
    localparam logic [1:0]  CLEAR = 2'd3;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    logic        clock;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic        done;
    logic [31:0] result;
    logic        pipe_en;
    logic [31:0] pipe_dataa;
    logic [31:0] pipe_result;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] res;
    int          lat;
    logic [31:0] vals [DEPTH+1];

    cordic_ci_sequencer #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .clk_en      (clk_en),
        .start       (start),
        .n           (n),
        .dataa       (dataa),
        .done        (done),
        .result      (result),
        .pipe_en     (pipe_en),
        .pipe_dataa  (pipe_dataa),
        .pipe_result (pipe_result)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Pipeline stub: an operand sampled at edge Ei is on pipe_result after E(i+LAT).
    logic [31:0] dl [LAT];
    always @(posedge clock) begin
        if (pipe_en) begin
            dl[0] <= pipe_dataa + 32'd1;
            for (int j = 1; j < LAT; j++) dl[j] <= dl[j-1];
            pipe_result <= dl[LAT-1];
        end
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issues one instruction from a falling edge and waits (bounded) for done;
    // lat is the number of raw clock edges from the start-sampling edge to done.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] data,
                                 output logic [31:0] r, output int l);
        logic seen;
        seen  = 1'b0;
        r     = '0;
        l     = -1;
        start = 1'b1;
        n     = op;
        dataa = data;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                r    = result;
                l    = c;
                break;
            end
        end
        checkOutput("done_seen", {31'b0, seen}, 32'd1);
    endtask

    // Directed scenarios run back to back.
    initial begin
        reset_n = 1'b0;
        clk_en  = 1'b1;
        start   = 1'b0;
        n       = 2'd0;
        dataa   = '0;

        repeat (2) @(negedge clock);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_pipe_en", {31'b0, pipe_en}, 32'd0);
        checkOutput("reset_pipe_dataa", pipe_dataa, 32'd0);
        reset_n = 1'b1;

        $display("[TB] push and run");
        applyStimulus(PUSH, 32'h41c8_0000, res, lat);
        checkOutput("push1_res", res, 32'd1);
        checkOutput("push1_lat", 32'(lat), 32'd1);
        applyStimulus(PUSH, 32'h4248_0000, res, lat);
        checkOutput("push2_res", res, 32'd2);
        applyStimulus(RUN, 32'h0, res, lat);
        checkOutput("run1_res", res, 32'd2);
        checkOutput("run1_lat", 32'(lat), 32'd19);
        applyStimulus(POP, 32'h0, res, lat);
        checkOutput("pop1_res", res, 32'h41c8_0001);
        checkOutput("pop1_lat", 32'(lat), 32'd1);
        applyStimulus(POP, 32'h0, res, lat);
        checkOutput("pop2_res", res, 32'h4248_0001);
        applyStimulus(POP, 32'h0, res, lat);
        checkOutput("pop3_nan", res, QNAN);

        $display("[TB] full fifo");
        for (int i = 0; i <= DEPTH; i++) begin
            vals[i] = 32'h4000_0000 + 32'(i * 16);
            applyStimulus(PUSH, vals[i], res, lat);
            checkOutput("fill_push", res, (i < DEPTH) ? 32'(i + 1) : 32'hFFFF_FFFF);
        end
        applyStimulus(RUN, 32'h0, res, lat);
        checkOutput("run8_res", res, 32'd8);
        checkOutput("run8_lat", 32'(lat), 32'd25);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(POP, 32'h0, res, lat);
            checkOutput("run8_pop", res, vals[i] + 32'd1);
        end

        $display("[TB] empty and clear");
        applyStimulus(RUN, 32'h0, res, lat);
        checkOutput("run_empty_res", res, 32'd0);
        checkOutput("run_empty_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(PUSH, 32'h3f80_0000 + 32'(i), res, lat);
            checkOutput("clr_push", res, 32'(i + 1));
        end
        applyStimulus(CLEAR, 32'h0, res, lat);
        checkOutput("clear_res", res, 32'd0);
        checkOutput("clear_lat", 32'(lat), 32'd1);
        applyStimulus(POP, 32'h0, res, lat);
        checkOutput("clear_pop_nan", res, QNAN);
        applyStimulus(PUSH, 32'h1234_0000, res, lat);
        checkOutput("clear_push_cnt", res, 32'd1);
        applyStimulus(CLEAR, 32'h0, res, lat);

        $display("[TB] enable stall");
        for (int i = 0; i < 4; i++) begin
            vals[i] = 32'h5000_0000 + 32'(i * 3);
            applyStimulus(PUSH, vals[i], res, lat);
        end
        fork
            applyStimulus(RUN, 32'h0, res, lat);
            begin
                repeat (4) @(negedge clock);
                checkOutput("stall_pipe_en_hi", {31'b0, pipe_en}, 32'd1);
                @(negedge clock);
                clk_en = 1'b0;
                #1;
                checkOutput("stall_pipe_en_lo", {31'b0, pipe_en}, 32'd0);
                repeat (5) @(negedge clock);
                clk_en = 1'b1;
            end
        join
        checkOutput("stall_res", res, 32'd4);
        checkOutput("stall_lat", 32'(lat), 32'd26);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(POP, 32'h0, res, lat);
            checkOutput("stall_pop", res, vals[i] + 32'd1);
        end

        $display("[TB] busy start");
        for (int i = 0; i < 3; i++) begin
            vals[i] = 32'h6000_0100 + 32'(i * 32);
            applyStimulus(PUSH, vals[i], res, lat);
        end
        fork
            applyStimulus(RUN, 32'h0, res, lat);
            begin
                repeat (4) @(negedge clock);
                start = 1'b1;
                n     = CLEAR;
                @(negedge clock);
                start = 1'b0;
            end
        join
        checkOutput("busy_res", res, 32'd3);
        checkOutput("busy_lat", 32'(lat), 32'd20);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(POP, 32'h0, res, lat);
            checkOutput("busy_pop", res, vals[i] + 32'd1);
        end

        $display("[TB] reset mid-run");
        applyStimulus(PUSH, 32'h7000_0010, res, lat);
        applyStimulus(PUSH, 32'h7000_0020, res, lat);
        checkOutput("rst_push2", res, 32'd2);
        start = 1'b1;
        n     = RUN;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("rst_pre_pipe_en", {31'b0, pipe_en}, 32'd1);
        checkOutput("rst_pre_pipe_dataa", pipe_dataa, 32'h7000_0020);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_pipe_en", {31'b0, pipe_en}, 32'd0);
        checkOutput("rst_pipe_dataa", pipe_dataa, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(POP, 32'h0, res, lat);
        checkOutput("rst_pop_nan", res, QNAN);
        applyStimulus(PUSH, 32'h7000_0030, res, lat);
        checkOutput("rst_push_cnt", res, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/cordic_ci_sequencer.md
# cordic_ci_sequencer

Nios II extended multicycle custom-instruction responder that batches operands from the CPU, streams them back-to-back into a fixed-latency pipelined float datapath (the inner-function pipeline), and returns the collected results one per instruction. It sits between the custom-instruction port and the pipeline. It is the CPU-facing partner of the pipeline, taking over the streaming and collection the pipeline bench does today.

## Interface
- `DEPTH`, default 8: operand and result FIFO depth; must be a power of 2, ≥2.
- `LATENCY`, default 16: pipeline latency in `pipe_en` edges, ≥1.
- `clock` in 1: single clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `clk_en` in 1: CI clock enable; when low, all state freezes.
- `start` in 1: CI start; sampled only when `clk_en`=1 and in IDLE.
- `n` in 2: opcode. 0 PUSH, 1 RUN, 2 POP, 3 CLEAR.
- `dataa` in 32: operand for PUSH, IEEE-754 single.
- `done` out 1: one-cycle completion pulse, registered.
- `result` out 32: valid only while `done`=1, registered.
- `pipe_en` out 1: clock enable to the pipeline.
- `pipe_dataa` out 32: operand to the pipeline.
- `pipe_result` in 32: pipeline output.

## Operation
- States are IDLE, ACK and RUN. ACK is a single cycle used by PUSH, POP and CLEAR.
- **PUSH**
  - If the operand FIFO is not full: write `dataa`; `result` = new operand count.
  - If the operand FIFO is full: no write; `result` = 32'hFFFFFFFF.
- **POP**
  - If the result FIFO is non-empty: `result` = head, and the head is popped.
  - If the result FIFO is empty: `result` = 32'h7FC00000 (qNaN).
- **CLEAR**: both FIFOs are emptied and the tag register is zeroed; `result` = 0.
- **RUN**
  - If the operand FIFO is empty: behave as ACK with `result` = 0.
  - Otherwise, on entry:
    - The result FIFO is emptied.
    - `k` = operand count is latched.
    - Operands are popped one per enabled cycle onto `pipe_dataa`.
  - A `LATENCY`-bit valid-tag shift register advances on every `pipe_en` edge.
  - When a tag exits, `pipe_result` is written to the result FIFO.
  - After `k` captures: `done` is pulsed, `result` = `k`, and the state returns to IDLE.
  - The operand FIFO is empty afterwards.
- `pipe_en` = `clk_en` AND (state==RUN).
- `pipe_dataa` holds the last issued value after the final issue. It is "don't care" while no tag is being injected.
- FIFO pointers are `log2(DEPTH)+1` bits and wrap modulo 2·`DEPTH`.
  - full = MSBs differ and LSBs are equal.
  - empty = pointers are equal.
- `start` while not IDLE is a protocol violation. It is ignored, with no state change.

## Timing
- Reset values: `done`=0, `result`=0, `pipe_en`=0, `pipe_dataa`=0. State is IDLE, both FIFOs are empty, and tags are 0.
- An async assert mid-RUN aborts immediately: pipeline results in flight are discarded and queued data is lost.
- Deassertion is synchronized externally. The first `start` is accepted at the first enabled edge after release.
- PUSH, POP and CLEAR: `start` is sampled at edge E0; `done` is high for the cycle after E1.
- RUN with `k` operands, `start` sampled at E0:
  - The pipeline samples operands at enabled edges E1…Ek.
  - The operand sampled at Ei is captured at E(i+LATENCY+1).
  - `done` rises after E(k+LATENCY+1) and lasts one enabled cycle.
- All counts in this section are enabled edges. When `clk_en` is low, `done`, `result`, the tags and the FIFOs hold.
- `done` drops on the next enabled edge.

## Structure
- The shared package `ci_seq_pkg` holds:
  - opcode constants `OP_PUSH`/`OP_RUN`/`OP_POP`/`OP_CLEAR`;
  - `ERR_FULL`=32'hFFFFFFFF and `EMPTY_NAN`=32'h7FC00000;
  - the state enum `ci_state_t`.
- Sub-module `sync_fifo` (32-bit, parameter `DEPTH`, async active-low reset, synchronous flush, count output) is instantiated twice: operand FIFO and result FIFO.
- Tag shift register, FSM and response mux live at top level.

## Test plan
Bench stub: delay line with `LATENCY`=16 returning `dataa`+1 in integer form.
- **Push and run.** PUSH 32'h41c80000, then 32'h42480000, then RUN, then 3× POP.
  - PUSH results: 1, then 2.
  - RUN: `done` exactly 19 cycles after `start` (2+16+1); `result`=2.
  - POP results: 32'h41c80001, 32'h42480001, 32'h7FC00000.
- **Full FIFO.** 9 PUSHes (`DEPTH`=8) -> 9th returns 32'hFFFFFFFF. RUN returns 8. 8 POPs return the operands+1 in order, which exercises pointer wrap.
- **Empty and clear.** RUN with empty FIFO -> `done` after E1, `result`=0. CLEAR after 3 PUSHes -> `result`=0; next POP gives the qNaN.
- **Enable stall.** `clk_en` low for 5 cycles mid-RUN with `k`=4 -> `pipe_en` low for those cycles; `done` 5 cycles later than 21; results are unchanged.
- **Reset mid-RUN.** `reset_n` low 2 cycles into a RUN -> all outputs 0 immediately. A subsequent POP returns 32'h7FC00000, and PUSH returns 1.
- **Busy start.** `start` during RUN with `n`=3 -> ignored; the RUN completes with the correct count.
